// File: rtl/piso_serializer_pkg.sv
// piso_serializer_pkg
// Shared types and sizing helpers for the parallel-in/serial-out serializer.
// Configuration macro: PISO_SERIALIZER_PARITY_EN adds one even-parity bit
// after the data bits of every frame.
// No ports. This file holds the state enum, the frame-length and
// counter-width helpers, and the frame length for the default 8-bit word.

package piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  localparam int DEFAULT_WIDTH = 8;
  localparam int FRAME_LEN     = DEFAULT_WIDTH + PARITY_BITS;

  // Number of bits on the wire for one word of the given width.
  function automatic int frame_len(input int width);
    return width + PARITY_BITS;
  endfunction

  // The bit counter must hold indices up to the parity slot, so it is sized for width+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// piso_serializer_if
// Bundles the word handshake, the bit-rate enable and the serial outputs
// of the serializer.
// Parameter: WIDTH, the number of data bits per word.
// Signals:
//   in_data   : parallel word offered by the source
//   in_valid  : in_data is valid
//   in_ready  : serializer accepts in_data this cycle
//   shift_en  : bit-rate enable from the downstream side
//   ser_out   : serial bit
//   ser_valid : ser_out carries a frame bit
//   busy      : a frame is in progress
//   done      : one-cycle pulse after the last bit of a frame is consumed
// The master modport is the environment side; the slave modport is the serializer.

interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             shift_en;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             done;

  modport master (
    output in_data, in_valid, shift_en,
    input  in_ready, ser_out, ser_valid, busy, done
  );

  modport slave (
    input  in_data, in_valid, shift_en,
    output in_ready, ser_out, ser_valid, busy, done
  );
endinterface

// File: rtl/piso_serializer_bit_counter.sv
// piso_bit_counter
// Counts the bit position inside a serial frame.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset, clears the count
//   clr      : synchronous return to zero, takes priority over inc
//   inc      : advance the count by one
//   last_idx : index of the final bit of a frame
//   count    : current bit index
//   is_last  : count equals last_idx

module piso_bit_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic [CW-1:0] last_idx,
  output logic [CW-1:0] count,
  output logic          is_last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

  assign is_last = (count == last_idx);

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer
// Parallel-in, serial-out stage. A word is accepted over a valid/ready
// handshake and sent one bit per enabled clock. Words can follow back-to-back
// with no idle bit in between.
// Configuration macro: PISO_SERIALIZER_PARITY_EN appends an even-parity bit
// to every frame.
// Parameters:
//   WIDTH     : data bits per word (minimum 2)
//   MSB_FIRST : 1 sends bit WIDTH-1 first, 0 sends bit 0 first
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; abandons any frame in progress
//   bus   : piso_serializer_if slave modport (handshake, shift_en, serial outputs)

module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input logic               clk,
  input logic               rst_n,
  piso_serializer_if.slave  bus
);

  localparam int FRAME_BITS = frame_len(WIDTH);
  localparam int CW         = cnt_width(WIDTH);

  state_t                state;
  state_t                state_next;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] load_word;
  logic [CW-1:0]         count;
  logic                  is_last;
  logic                  consume;
  logic                  last_consume;
  logic                  load;
  logic                  head;
  logic                  done_q;

  assign consume      = (state == SHIFT) && bus.shift_en;
  assign last_consume = consume && is_last;

  // Ready is gated by rst_n so that it reads 0 while reset is held.
  // It also opens on the last consumed bit, which allows a zero-gap reload.
  assign bus.in_ready = rst_n && ((state == IDLE) || last_consume);
  assign load         = bus.in_valid && bus.in_ready;

  // The parity bit is placed at the tail end of the shift direction,
  // so it leaves after the data bits without a separate register.
  always_comb begin
`ifdef PISO_SERIALIZER_PARITY_EN
    if (MSB_FIRST != 0) begin
      load_word = {bus.in_data, ^bus.in_data};
    end else begin
      load_word = {^bus.in_data, bus.in_data};
    end
`else
    load_word = bus.in_data;
`endif
  end

  assign head = (MSB_FIRST != 0) ? shreg[FRAME_BITS-1] : shreg[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    bus.ser_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.ser_out   = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        bus.ser_valid = 1'b1;
        bus.busy      = 1'b1;
        bus.ser_out   = head;
        if (last_consume && !load) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A load wins over a shift, which covers a back-to-back reload on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_consume;
      if (load) begin
        shreg <= load_word;
      end else if (consume) begin
        if (MSB_FIRST != 0) begin
          shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
        end else begin
          shreg <= {1'b0, shreg[FRAME_BITS-1:1]};
        end
      end
    end
  end

  assign bus.done = done_q;

  // The count stops at the last index instead of stepping past it,
  // so it never exceeds the counter's range within a frame.
  piso_bit_counter #(
    .CW (CW)
  ) u_bit_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (load),
    .inc      (consume && !is_last),
    .last_idx (CW'(FRAME_BITS - 1)),
    .count    (count),
    .is_last  (is_last)
  );

  count_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CW'(FRAME_BITS - 1));

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer
// Drives two serializers from the same stimulus: lane 0 is MSB-first and
// lane 1 is LSB-first. A frame-level model predicts every output on every
// cycle. Hand-computed literals pin the serial streams of the directed words.
// Configuration macro: PISO_SERIALIZER_PARITY_EN selects the parity frame length.

module tb_piso_serializer;

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       shift_en;

  int n_vec  = 0;
  int n_fail = 0;

  piso_serializer_if #(.WIDTH(8)) bus_m ();
  piso_serializer_if #(.WIDTH(8)) bus_l ();

  assign bus_m.in_data  = in_data;
  assign bus_m.in_valid = in_valid;
  assign bus_m.shift_en = shift_en;
  assign bus_l.in_data  = in_data;
  assign bus_l.in_valid = in_valid;
  assign bus_l.shift_en = shift_en;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (.clk(clk), .rst_n(rst_n), .bus(bus_m));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (.clk(clk), .rst_n(rst_n), .bus(bus_l));

  always #5 clk = ~clk;

  logic [1:0] dut_out, dut_valid, dut_busy, dut_ready, dut_done;
  assign dut_out   = {bus_l.ser_out,   bus_m.ser_out};
  assign dut_valid = {bus_l.ser_valid, bus_m.ser_valid};
  assign dut_busy  = {bus_l.busy,      bus_m.busy};
  assign dut_ready = {bus_l.in_ready,  bus_m.in_ready};
  assign dut_done  = {bus_l.done,      bus_m.done};

  // Frame model: a lane holds the word in flight and the number of bits already consumed.
  bit         m_active [2];
  logic [7:0] m_word   [2];
  int         m_idx    [2];
  bit         m_done   [2];

  // Bit k of the frame, where k=8 is the parity slot.
  function automatic bit frame_bit(input logic [7:0] w, input int k, input int lane);
    if (k >= 8) return ^w;
    return (lane == 0) ? w[7-k] : w[k];
  endfunction

  function automatic bit exp_ready(input int lane);
    return rst_n && (!m_active[lane] || (m_idx[lane] == FLEN - 1 && shift_en));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < 2; l++) begin
        m_active[l] = 1'b0;
        m_idx[l]    = 0;
        m_done[l]   = 1'b0;
        m_word[l]   = '0;
      end
    end else begin
      for (int l = 0; l < 2; l++) begin
        bit acc;
        bit fin;
        acc = in_valid && exp_ready(l);
        fin = m_active[l] && shift_en && (m_idx[l] == FLEN - 1);
        if (m_active[l] && shift_en) begin
          m_idx[l]++;
          if (m_idx[l] == FLEN) m_active[l] = 1'b0;
        end
        if (acc) begin
          m_word[l]   = in_data;
          m_idx[l]    = 0;
          m_active[l] = 1'b1;
        end
        m_done[l] = fin;
      end
    end
  end

  // Per-test capture of what the DUT actually put on the wire.
  int          cyc;
  int          cap_cnt  [2];
  int          done_cnt [2];
  int          done_cyc [2];
  int          first_v  [2];
  int          last_v   [2];
  int          rdy_frm  [2];
  logic [15:0] cons     [2];

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareModel();
    for (int l = 0; l < 2; l++) begin
      checkOutput($sformatf("ser_valid[%0d]", l), 16'(dut_valid[l]), 16'(m_active[l]));
      checkOutput($sformatf("busy[%0d]", l), 16'(dut_busy[l]), 16'(m_active[l]));
      checkOutput($sformatf("ser_out[%0d]", l), 16'(dut_out[l]),
                  16'(m_active[l] ? frame_bit(m_word[l], m_idx[l], l) : 1'b0));
      checkOutput($sformatf("in_ready[%0d]", l), 16'(dut_ready[l]), 16'(exp_ready(l)));
      checkOutput($sformatf("done[%0d]", l), 16'(dut_done[l]), 16'(m_done[l]));
    end
  endtask

  task automatic clearCapture();
    cyc = 0;
    for (int l = 0; l < 2; l++) begin
      cap_cnt[l]  = 0;
      done_cnt[l] = 0;
      done_cyc[l] = -1;
      first_v[l]  = -1;
      last_v[l]   = -1;
      rdy_frm[l]  = 0;
      cons[l]     = '0;
    end
  endtask

  // One cycle: drive the inputs just after the rising edge, then sample and compare on the falling edge.
  task automatic applyStimulus(input logic r, input logic [7:0] d, input logic v,
                               input logic s, output bit accepted);
    @(posedge clk);
    #1;
    rst_n    = r;
    in_data  = d;
    in_valid = v;
    shift_en = s;
    @(negedge clk);
    compareModel();
    for (int l = 0; l < 2; l++) begin
      if (dut_valid[l]) begin
        cap_cnt[l]++;
        if (first_v[l] < 0) first_v[l] = cyc;
        last_v[l] = cyc;
        if (dut_ready[l]) rdy_frm[l]++;
        if (s) cons[l] = {cons[l][14:0], dut_out[l]};
      end
      if (dut_done[l]) begin
        done_cnt[l]++;
        done_cyc[l] = cyc;
      end
    end
    accepted = v && dut_ready[0];
    cyc++;
  endtask

  initial begin
    bit         acc;
    int         idx;
    logic [7:0] words [2];
    words[0] = 8'hFF;
    words[1] = 8'h00;

    rst_n    = 1'b1;
    in_data  = '0;
    in_valid = 1'b0;
    shift_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset ser_valid", 16'(dut_valid), 16'h0);
    checkOutput("reset ser_out",   16'(dut_out),   16'h0);
    checkOutput("reset busy",      16'(dut_busy),  16'h0);
    checkOutput("reset done",      16'(dut_done),  16'h0);
    checkOutput("reset in_ready",  16'(dut_ready), 16'h0);
    clearCapture();
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, acc);

    // Single word A5 with shift_en held high.
    clearCapture();
    applyStimulus(1'b1, 8'hA5, 1'b1, 1'b1, acc);
    checkOutput("release in_ready", 16'(dut_ready), 16'h3);
    checkOutput("A5 accepted", 16'(acc), 16'h1);
    repeat (FLEN + 1) applyStimulus(1'b1, 8'hA5, 1'b0, 1'b1, acc);
    checkOutput("A5 ready after frame", 16'(dut_ready), 16'h3);
`ifndef PISO_SERIALIZER_PARITY_EN
    checkOutput("A5 msb stream", cons[0], 16'h00A5);
    checkOutput("A5 lsb stream", cons[1], 16'h00A5);
    checkOutput("A5 valid cycles", 16'(cap_cnt[0]), 16'd8);
    checkOutput("A5 done cycle", 16'(done_cyc[0]), 16'd9);
    checkOutput("A5 done count", 16'(done_cnt[1]), 16'd1);
`endif

    // Word 01: the LSB-first lane sends a single 1 followed by seven 0s.
    clearCapture();
    applyStimulus(1'b1, 8'h01, 1'b1, 1'b1, acc);
    repeat (FLEN + 1) applyStimulus(1'b1, 8'h01, 1'b0, 1'b1, acc);
`ifndef PISO_SERIALIZER_PARITY_EN
    checkOutput("01 lsb stream", cons[1], 16'h0080);
    checkOutput("01 msb stream", cons[0], 16'h0001);
`endif

    // Word C3 with shift_en alternating, so each bit is held for two cycles.
    clearCapture();
    applyStimulus(1'b1, 8'hC3, 1'b1, 1'b0, acc);
    for (int k = 1; k <= 2 * FLEN + 1; k++) begin
      applyStimulus(1'b1, 8'hC3, 1'b0, logic'(k % 2 == 0), acc);
    end
`ifndef PISO_SERIALIZER_PARITY_EN
    checkOutput("C3 valid cycles", 16'(cap_cnt[0]), 16'd16);
    checkOutput("C3 msb stream", cons[0], 16'h00C3);
    checkOutput("C3 lsb stream", cons[1], 16'h00C3);
    checkOutput("C3 done cycle", 16'(done_cyc[0]), 16'd17);
`endif

    // Words FF then 00 with in_valid held, sent back-to-back.
    clearCapture();
    idx = 0;
    for (int k = 0; k <= 2 * FLEN + 1; k++) begin
      applyStimulus(1'b1, (idx < 2) ? words[idx] : 8'h00, logic'(idx < 2), 1'b1, acc);
      if (acc) idx++;
    end
    checkOutput("b2b both accepted", 16'(idx), 16'd2);
`ifndef PISO_SERIALIZER_PARITY_EN
    checkOutput("b2b valid cycles", 16'(cap_cnt[0]), 16'd16);
    checkOutput("b2b span", 16'(last_v[0] - first_v[0] + 1), 16'd16);
    checkOutput("b2b msb stream", cons[0], 16'hFF00);
    checkOutput("b2b lsb stream", cons[1], 16'hFF00);
    checkOutput("b2b ready in frame", 16'(rdy_frm[0]), 16'd2);
    checkOutput("b2b done count", 16'(done_cnt[0]), 16'd2);
`endif

    // Word 5A is abandoned by reset while its fourth bit is on the wire.
    clearCapture();
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b1, acc);
    repeat (4) applyStimulus(1'b1, 8'h5A, 1'b0, 1'b1, acc);
    checkOutput("5A mid-frame valid", 16'(dut_valid), 16'h3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async rst ser_valid", 16'(dut_valid), 16'h0);
    checkOutput("async rst busy",      16'(dut_busy),  16'h0);
    checkOutput("async rst in_ready",  16'(dut_ready), 16'h0);
    checkOutput("async rst ser_out",   16'(dut_out),   16'h0);
    checkOutput("async rst done",      16'(dut_done),  16'h0);
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, acc);
    checkOutput("5A no done", 16'(done_cnt[0] + done_cnt[1]), 16'd0);
    clearCapture();
    applyStimulus(1'b1, 8'h3C, 1'b1, 1'b1, acc);
    repeat (FLEN + 1) applyStimulus(1'b1, 8'h3C, 1'b0, 1'b1, acc);
    checkOutput("3C done count", 16'(done_cnt[0]), 16'd1);
`ifndef PISO_SERIALIZER_PARITY_EN
    checkOutput("3C msb stream", cons[0], 16'h003C);
    checkOutput("3C lsb stream", cons[1], 16'h003C);
`endif

`ifdef PISO_SERIALIZER_PARITY_EN
    // Word 07 with a parity bit: nine bits, and the parity bit is 1.
    clearCapture();
    applyStimulus(1'b1, 8'h07, 1'b1, 1'b1, acc);
    repeat (10) applyStimulus(1'b1, 8'h07, 1'b0, 1'b1, acc);
    checkOutput("07 valid cycles", 16'(cap_cnt[0]), 16'd9);
    checkOutput("07 msb stream", cons[0], 16'h000F);
    checkOutput("07 lsb stream", cons[1], 16'h01C1);
    checkOutput("07 parity bit", 16'(cons[1][0]), 16'h1);
    checkOutput("07 done cycle", 16'(done_cyc[0]), 16'd10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out stage that feeds the serial input of the downstream 2-bit shift register.
- Accepts a WIDTH-bit word through a valid/ready handshake.
- Emits the word one bit per enabled clock on `ser_out`, qualified by `ser_valid`.
- Supports back-to-back words with no idle bit between them.

Parameters:
- WIDTH, 8, number of data bits per word (minimum 2).
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- shift_en  input  1  bit-rate enable; serial output advances only when high.
- ser_out  output  1  serial bit; drives the downstream `d`.
- ser_valid  output  1  ser_out carries a frame bit.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse when the last bit of a frame is consumed.

Behaviour:
- Reset is asynchronous and active-low, on rst_n. While rst_n=0:
  - State = IDLE.
  - ser_out = 0, ser_valid = 0, busy = 0, done = 0, in_ready = 0.
  - Shift register and bit counter are cleared.
- Reset can occur mid-frame. The frame is abandoned, no done pulse is produced, and the word is lost.
- After release, in_ready is 1 in the first cycle.
- States: IDLE and SHIFT.
- IDLE:
  - in_ready = 1, ser_valid = 0, ser_out = 0.
  - If in_valid=1 at a rising edge: load the word into the shift register, set count = 0, go to SHIFT.
- SHIFT:
  - ser_valid = 1 and busy = 1.
  - ser_out is the current head bit of the shift register (registered, no combinational path from in_data).
  - On an edge with shift_en=1, the current bit is consumed: shift by one and increment count.
  - With shift_en=0, hold everything.
  - The current bit is the last one when count = FRAME_LEN-1, where FRAME_LEN = WIDTH (WIDTH+1 with parity).
- in_ready = (state==IDLE) || (state==SHIFT && last bit && shift_en).
- When the last bit is consumed:
  - done = 1 for the following cycle.
  - If in_valid=1 on the same edge, load the new word, stay in SHIFT with count = 0, and present the first bit next cycle (zero-gap back-to-back).
  - Otherwise go to IDLE.
- Latency: a word accepted at edge N presents its first bit in cycle N+1. With shift_en held high, a frame occupies FRAME_LEN cycles.
- Ordering: MSB_FIRST=1 shifts left (head = bit WIDTH-1); MSB_FIRST=0 shifts right (head = bit 0).
- Counter width is $clog2(WIDTH+1). The counter never wraps within a frame and is reset to 0 on each load.
- in_valid while in_ready=0 is ignored. The source must hold in_valid/in_data until accepted.

Optional Feature:
- Macro: PISO_SERIALIZER_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of all WIDTH data bits, computed at load) is sent as one extra bit after the data.
  - FRAME_LEN = WIDTH+1.
  - done and the back-to-back ready window follow the parity bit.
- Undefined: no parity bit, FRAME_LEN = WIDTH, and no parity register is synthesized.

Decomposition:
- Shared package piso_serializer_pkg holds:
  - the state enum (IDLE, SHIFT);
  - a helper function for counter width;
  - a FRAME_LEN localparam derived from WIDTH and the macro.
- One natural sub-module: piso_bit_counter.
  - Contents: enable-gated counter with synchronous load-to-zero and an is_last flag.
  - Ports: clk, rst_n, clr, inc, last_idx, count, is_last.

Test Plan:
1. Reset, then in_data=8'hA5 with in_valid=1 and shift_en=1 constant.
   - Required: ser_out = 1,0,1,0,0,1,0,1 on cycles 1-8, ser_valid high for exactly 8 cycles, done pulse on cycle 9, in_ready back to 1.
2. MSB_FIRST=0 with in_data=8'h01.
   - Required: first bit 1, then seven 0s.
3. shift_en toggling 1,0,1,0.
   - Required: each bit is held for 2 cycles and the frame spans 16 cycles for 8'hC3.
4. Back-to-back words 8'hFF then 8'h00 with in_valid held.
   - Required: 16 contiguous ser_valid cycles (eight 1s, eight 0s), in_ready high only on the last-bit cycle, and no idle gap.
5. Assert rst_n=0 on bit 4 of 8'h5A.
   - Required: outputs clear immediately without waiting for clk, no done pulse, and a subsequent 8'h3C serializes correctly.
6. With PISO_SERIALIZER_PARITY_EN, send 8'h07.
   - Required: 9 bits, the last (parity) bit is 1, and done follows the 9th bit.
